// File: rtl/ct_had_trace_pkg.sv
// Shared definitions for the HAD multi-lane trace block: FSM encoding,
// default geometry and a constant-foldable clog2.
package ct_had_trace_pkg;

    localparam int CT_TRACE_CNT_W_DEF    = 8;
    localparam int CT_TRACE_RETIRE_W_DEF = 3;

    typedef logic [1:0] ct_trace_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    function automatic int ct_clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ct_had_trace_lane_sel.sv
// Combinational lane selector: counts valid retire lanes, decides whether the
// trace counter expires inside this retire group and names the expiring lane.
module ct_had_trace_lane_sel
    import ct_had_trace_pkg::*;
#(
    parameter int CNT_W    = CT_TRACE_CNT_W_DEF,
    parameter int RETIRE_W = CT_TRACE_RETIRE_W_DEF,
    localparam int LANE_W  = (ct_clog2(RETIRE_W) > 1) ? ct_clog2(RETIRE_W) : 1,
    localparam int POP_W   = ct_clog2(RETIRE_W + 1)
) (
    input  logic [RETIRE_W-1:0] i_vld,
    input  logic [CNT_W-1:0]    i_cnt,
    output logic [POP_W-1:0]    o_vld_cnt,
    output logic                o_hit,
    output logic [LANE_W-1:0]   o_lane
);

    // One extra bit so that counter+1 never overflows in the lane search.
    localparam int CMP_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    logic [CMP_W-1:0] w_run;
    logic [CMP_W-1:0] w_target;

    always_comb begin
        w_run    = '0;
        w_target = CMP_W'(i_cnt) + CMP_W'(1);
        o_lane   = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            if (i_vld[i]) begin
                w_run = w_run + CMP_W'(1);
                if (w_run == w_target) begin
                    o_lane = LANE_W'(i);
                end
            end
        end
    end

    assign o_vld_cnt = POP_W'(w_run);
    assign o_hit     = (w_run > CMP_W'(i_cnt));

endmodule

// File: rtl/ct_had_trace_mlane.sv
// HAD trace-mode controller for a multi-lane retire stage: counts retired
// instructions down and raises a held debug request when the count expires.
// Optional 32-bit total retire counter enabled by CT_HAD_TRACE_TOTAL_CNT_EN.
module ct_had_trace_mlane
    import ct_had_trace_pkg::*;
#(
    parameter int CNT_W    = CT_TRACE_CNT_W_DEF,
    parameter int RETIRE_W = CT_TRACE_RETIRE_W_DEF,
    localparam int LANE_W  = (ct_clog2(RETIRE_W) > 1) ? ct_clog2(RETIRE_W) : 1,
    localparam int POP_W   = ct_clog2(RETIRE_W + 1)
) (
    input  logic                cpuclk,
    input  logic                cpurst_b,
    input  logic                ctrl_trace_en,
    input  logic                ctrl_trace_ack,
    input  logic                inst_bkpt_dbgreq,
    input  logic [RETIRE_W-1:0] rtu_yy_xx_retire_normal,
    input  logic [RETIRE_W-1:0] rtu_had_xx_split_inst,
    input  logic                rtu_yy_xx_dbgon,
    input  logic                x_sm_xx_update_dr_en,
    input  logic                ir_xx_otc_reg_sel,
    input  logic [63:0]         ir_xx_wdata,
    output logic                trace_ctrl_req,
    output logic [LANE_W-1:0]   trace_req_lane,
    output logic [CNT_W-1:0]    trace_regs_otc,
    output logic [1:0]          trace_fsm_state
`ifdef CT_HAD_TRACE_TOTAL_CNT_EN
    ,
    output logic [31:0]         trace_total_cnt
`endif
);

    localparam int DEC_W = ((CNT_W > POP_W) ? CNT_W : POP_W);

    ct_trace_state_t     r_state;
    ct_trace_state_t     w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [LANE_W-1:0]   r_lane;
    logic [RETIRE_W-1:0] w_vld;
    logic [POP_W-1:0]    w_vld_cnt;
    logic                w_hit;
    logic [LANE_W-1:0]   w_sel_lane;
    logic                w_in_run;
    logic                w_trig;
    logic                w_dec;
    logic                w_wr;
    logic                w_unused_wdata;

    assign w_vld = rtu_yy_xx_retire_normal & ~rtu_had_xx_split_inst
                 & {RETIRE_W{~rtu_yy_xx_dbgon & ctrl_trace_en}};

    ct_had_trace_lane_sel #(
        .CNT_W    (CNT_W),
        .RETIRE_W (RETIRE_W)
    ) u_lane_sel (
        .i_vld     (w_vld),
        .i_cnt     (r_cnt),
        .o_vld_cnt (w_vld_cnt),
        .o_hit     (w_hit),
        .o_lane    (w_sel_lane)
    );

    // A memory breakpoint in the same cycle owns the debug entry, so trace
    // neither fires nor consumes the retired instructions.
    assign w_in_run = (r_state == ST_RUN);
    assign w_trig   = w_in_run & w_hit & ~inst_bkpt_dbgreq;
    assign w_dec    = w_in_run & ~w_hit & ~inst_bkpt_dbgreq;
    assign w_wr     = x_sm_xx_update_dr_en & ir_xx_otc_reg_sel;

    assign w_unused_wdata = ^ir_xx_wdata[63:CNT_W];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_trace_en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!ctrl_trace_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_trig) begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (ctrl_trace_ack) begin
                    w_state_nxt = ctrl_trace_en ? ST_RUN : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Register write wins over both the decrement and the trigger clear.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_wr) begin
            w_cnt_nxt = ir_xx_wdata[CNT_W-1:0];
        end else if (w_trig) begin
            w_cnt_nxt = '0;
        end else if (w_dec) begin
            if (DEC_W'(w_vld_cnt) >= DEC_W'(r_cnt)) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = CNT_W'(DEC_W'(r_cnt) - DEC_W'(w_vld_cnt));
            end
        end
    end

    always_ff @(posedge cpuclk) begin
        if (!cpurst_b) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_lane  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_trig) begin
                r_lane <= w_sel_lane;
            end
        end
    end

`ifdef CT_HAD_TRACE_TOTAL_CNT_EN
    logic [31:0] r_total;

    always_ff @(posedge cpuclk) begin
        if (!cpurst_b) begin
            r_total <= '0;
        end else if ((r_state != ST_IDLE) && !inst_bkpt_dbgreq) begin
            r_total <= r_total + 32'(w_vld_cnt);
        end
    end

    assign trace_total_cnt = r_total;
`endif

    assign trace_ctrl_req  = (r_state == ST_PEND);
    assign trace_req_lane  = r_lane;
    assign trace_regs_otc  = r_cnt;
    assign trace_fsm_state = r_state;

endmodule

// File: tb/tb_ct_had_trace_mlane.sv
// Self-checking bench for ct_had_trace_mlane (CNT_W=8, RETIRE_W=3): directed
// scenarios followed by randomized traffic against a lane-list reference model.
module tb_ct_had_trace_mlane;
    import ct_had_trace_pkg::*;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PEND = 2;

    logic        cpuclk;
    logic        cpurst_b;
    logic        ctrl_trace_en;
    logic        ctrl_trace_ack;
    logic        inst_bkpt_dbgreq;
    logic [2:0]  rtu_yy_xx_retire_normal;
    logic [2:0]  rtu_had_xx_split_inst;
    logic        rtu_yy_xx_dbgon;
    logic        x_sm_xx_update_dr_en;
    logic        ir_xx_otc_reg_sel;
    logic [63:0] ir_xx_wdata;
    logic        trace_ctrl_req;
    logic [1:0]  trace_req_lane;
    logic [7:0]  trace_regs_otc;
    logic [1:0]  trace_fsm_state;

    int errors = 0;
    int checks = 0;
    int m_mode = M_IDLE;
    int m_cnt  = 0;
    int m_lane = 0;

    ct_had_trace_mlane #(
        .CNT_W    (8),
        .RETIRE_W (3)
    ) dut (
        .cpuclk                  (cpuclk),
        .cpurst_b                (cpurst_b),
        .ctrl_trace_en           (ctrl_trace_en),
        .ctrl_trace_ack          (ctrl_trace_ack),
        .inst_bkpt_dbgreq        (inst_bkpt_dbgreq),
        .rtu_yy_xx_retire_normal (rtu_yy_xx_retire_normal),
        .rtu_had_xx_split_inst   (rtu_had_xx_split_inst),
        .rtu_yy_xx_dbgon         (rtu_yy_xx_dbgon),
        .x_sm_xx_update_dr_en    (x_sm_xx_update_dr_en),
        .ir_xx_otc_reg_sel       (ir_xx_otc_reg_sel),
        .ir_xx_wdata             (ir_xx_wdata),
        .trace_ctrl_req          (trace_ctrl_req),
        .trace_req_lane          (trace_req_lane),
        .trace_regs_otc          (trace_regs_otc),
        .trace_fsm_state         (trace_fsm_state)
    );

    initial cpuclk = 1'b0;
    always #5 cpuclk = ~cpuclk;

    function automatic logic [1:0] exp_state(input int mode);
        case (mode)
            M_RUN:   return ST_RUN;
            M_PEND:  return ST_PEND;
            default: return ST_IDLE;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference model with the inputs currently applied, clock
    // the DUT, then compare every output just after the edge.
    task automatic tick();
        int q[$];
        int n;
        int nmode;
        if (!cpurst_b) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            m_lane = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (rtu_yy_xx_retire_normal[i] && !rtu_had_xx_split_inst[i]
                    && !rtu_yy_xx_dbgon && ctrl_trace_en) begin
                    q.push_back(i);
                end
            end
            n = q.size();
            nmode = m_mode;
            if (m_mode == M_IDLE && ctrl_trace_en) nmode = M_RUN;
            if (m_mode == M_RUN && !ctrl_trace_en) nmode = M_IDLE;
            if (m_mode == M_PEND && ctrl_trace_ack) nmode = ctrl_trace_en ? M_RUN : M_IDLE;
            if (m_mode == M_RUN && !inst_bkpt_dbgreq) begin
                if (n > m_cnt) begin
                    m_lane = q[m_cnt];
                    m_cnt  = 0;
                    nmode  = M_PEND;
                end else begin
                    m_cnt = m_cnt - n;
                end
            end
            if (x_sm_xx_update_dr_en && ir_xx_otc_reg_sel) begin
                m_cnt = int'(ir_xx_wdata % 256);
            end
            m_mode = nmode;
        end
        @(posedge cpuclk);
        #1;
        check("req", 32'(trace_ctrl_req), 32'(m_mode == M_PEND));
        check("lane", 32'(trace_req_lane), 32'(m_lane));
        check("otc", 32'(trace_regs_otc), 32'(m_cnt));
        check("state", 32'(trace_fsm_state), 32'(exp_state(m_mode)));
    endtask

    task automatic idle_inputs();
        ctrl_trace_ack          = 1'b0;
        inst_bkpt_dbgreq        = 1'b0;
        rtu_yy_xx_retire_normal = 3'b000;
        rtu_had_xx_split_inst   = 3'b000;
        rtu_yy_xx_dbgon         = 1'b0;
        x_sm_xx_update_dr_en    = 1'b0;
        ir_xx_otc_reg_sel       = 1'b0;
        ir_xx_wdata             = 64'd0;
    endtask

    task automatic write_cnt(input logic [63:0] val);
        x_sm_xx_update_dr_en = 1'b1;
        ir_xx_otc_reg_sel    = 1'b1;
        ir_xx_wdata          = val;
    endtask

    initial begin
        cpurst_b      = 1'b0;
        ctrl_trace_en = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("reset_req", 32'(trace_ctrl_req), 32'd0);
        check("reset_otc", 32'(trace_regs_otc), 32'd0);
        cpurst_b = 1'b1;

        // Load 5, enable, three lanes per cycle: 5 -> 2 -> trigger on lane 2.
        write_cnt(64'd5);
        tick();
        idle_inputs();
        ctrl_trace_en = 1'b1;
        rtu_yy_xx_retire_normal = 3'b111;
        tick();
        check("s1_idle_hold", 32'(trace_regs_otc), 32'd5);
        tick();
        check("s1_dec", 32'(trace_regs_otc), 32'd2);
        tick();
        check("s1_req", 32'(trace_ctrl_req), 32'd1);
        check("s1_lane", 32'(trace_req_lane), 32'd2);
        check("s1_cnt0", 32'(trace_regs_otc), 32'd0);

        // Counter 1 with lane 1 split: second valid lane is lane 2.
        idle_inputs();
        ctrl_trace_ack = 1'b1;
        tick();
        idle_inputs();
        write_cnt(64'd1);
        tick();
        idle_inputs();
        rtu_yy_xx_retire_normal = 3'b111;
        rtu_had_xx_split_inst   = 3'b010;
        tick();
        check("s2_lane", 32'(trace_req_lane), 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s2_hold_req", 32'(trace_ctrl_req), 32'd1);
            check("s2_hold_cnt", 32'(trace_regs_otc), 32'd0);
        end

        // Breakpoint blocks the trigger for one cycle only.
        idle_inputs();
        ctrl_trace_ack = 1'b1;
        tick();
        idle_inputs();
        rtu_yy_xx_retire_normal = 3'b001;
        inst_bkpt_dbgreq = 1'b1;
        tick();
        check("s3_bkpt_noreq", 32'(trace_ctrl_req), 32'd0);
        inst_bkpt_dbgreq = 1'b0;
        tick();
        check("s3_req", 32'(trace_ctrl_req), 32'd1);
        check("s3_lane", 32'(trace_req_lane), 32'd0);

        // Write plus ack while pending: low byte loaded, back to RUN.
        idle_inputs();
        write_cnt(64'h1A4);
        ctrl_trace_ack = 1'b1;
        tick();
        check("s4_otc", 32'(trace_regs_otc), 32'hA4);
        check("s4_state", 32'(trace_fsm_state), 32'(ST_RUN));
        check("s4_req", 32'(trace_ctrl_req), 32'd0);

        // Debug mode and disabled trace do not count retirement.
        idle_inputs();
        rtu_yy_xx_retire_normal = 3'b111;
        rtu_yy_xx_dbgon = 1'b1;
        tick();
        check("s5_dbgon", 32'(trace_regs_otc), 32'hA4);
        rtu_yy_xx_dbgon = 1'b0;
        ctrl_trace_en = 1'b0;
        tick();
        check("s5_dis", 32'(trace_regs_otc), 32'hA4);
        check("s5_noreq", 32'(trace_ctrl_req), 32'd0);

        // Reset while pending drops the request without ack.
        idle_inputs();
        ctrl_trace_en = 1'b1;
        write_cnt(64'd0);
        tick();
        idle_inputs();
        rtu_yy_xx_retire_normal = 3'b100;
        tick();
        check("s6_pend", 32'(trace_ctrl_req), 32'd1);
        check("s6_lane", 32'(trace_req_lane), 32'd2);
        cpurst_b = 1'b0;
        tick();
        check("s6_rst_req", 32'(trace_ctrl_req), 32'd0);
        check("s6_rst_lane", 32'(trace_req_lane), 32'd0);
        check("s6_rst_otc", 32'(trace_regs_otc), 32'd0);
        cpurst_b = 1'b1;

        // Randomized traffic with small counter loads so triggers are common.
        for (int k = 0; k < 800; k++) begin
            cpurst_b                = ($urandom_range(0, 99) != 0);
            ctrl_trace_en           = ($urandom_range(0, 9) != 0);
            ctrl_trace_ack          = ($urandom_range(0, 3) == 0);
            inst_bkpt_dbgreq        = ($urandom_range(0, 9) == 0);
            rtu_yy_xx_retire_normal = 3'($urandom);
            rtu_had_xx_split_inst   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            rtu_yy_xx_dbgon         = ($urandom_range(0, 19) == 0);
            x_sm_xx_update_dr_en    = ($urandom_range(0, 7) == 0);
            ir_xx_otc_reg_sel       = ($urandom_range(0, 3) != 0);
            ir_xx_wdata             = {32'($urandom), 24'($urandom),
                                       ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                                   : 8'($urandom_range(0, 9))};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
